uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter sitting directly downstream of the MEM stage on the data-memory bus, alongside `dpram`. Stores from MEM that hit its address window push bytes into a small FIFO instead of RAM. A serialiser FSM shifts each byte out on `tx_o` as 8N1 frames. Loads hitting the window return a status word through a combinational read port that the top muxes over `dpram` data.

## Interface
Parameters:
- `BASE_ADDR`, 32'h1000_0000, word-aligned base of the 3-register window.
- `CLK_DIV`, 868, clock cycles per bit; legal range 2..65535.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, 2..16.

Ports:
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-low.
- `we_i` input 1: write request from MEM (`ram_w_request_o`).
- `addr_i` input `ADDR_WIDTH`: byte address from MEM.
- `data_i` input `DATA_WIDTH`: write data; only bits [7:0] are used.
- `sel_o` output 1: combinational; high when `addr_i` lies in [BASE_ADDR, BASE_ADDR+11].
- `rdata_o` output `DATA_WIDTH`: combinational register read data; 0 when `sel_o` is low.
- `tx_o` output 1: serial line, registered, idle high.
- `irq_o` output 1: present only with `UART_TX_IRQ_EN`.

## Operation
Registers:
- +0 TXDATA (write-only). A write pushes `data_i[7:0]`. Reads return 0.
- +4 STATUS. Read bits: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky). Writing 1 to bit 3 clears overflow. Other written bits are ignored.
- +8 CTRL. Bit [0] is irq_en (see Configuration).

Address decode:
- Writes are decoded on `addr_i[3:2]` while `sel_o` is high.
- Offset +12 and above, and writes to read-only bits, have no effect.

FIFO:
- Push occurs on `we_i & sel_o & offset 0`.
- When full and no pop occurs in the same cycle, the byte is dropped and overflow is set.
- When full and a pop occurs in the same cycle, the push is accepted.
- Push into an empty FIFO while the FSM is IDLE: the entry is stored, then popped on the next edge.

FSM states: IDLE → START → DATA → STOP → IDLE.
- IDLE: `tx_o`=1. If the FIFO is not empty, pop the head into the shift register, load the baud counter with CLK_DIV-1, drive `tx_o`=0, and go to START.
- START and each DATA bit hold for CLK_DIV cycles. The baud counter counts down and advances state on 0.
- DATA shifts out LSB first, 8 bits, tracked by a 3-bit bit index.
- STOP drives `tx_o`=1 for CLK_DIV cycles. At the end of STOP, the FSM pops immediately if the FIFO is non-empty (START directly, with no idle cycle); otherwise it goes to IDLE.

Reset:
- State IDLE, `tx_o`=1, FIFO empty, pointers 0, overflow 0, irq_en 0, `irq_o`=0.
- Assertion mid-frame aborts the frame immediately; `tx_o` returns high asynchronously.

## Timing
- Write accepted at edge E0. The FSM pops at E1, and `tx_o` falls after E1.
- Frame length is exactly 10×CLK_DIV cycles. Back-to-back frames have no gap.
- STATUS reflects state after the last edge, with zero-cycle combinational read.
- A write that clears overflow in the same cycle as an overflow event: set wins.
- `sel_o`/`rdata_o` are combinational from `addr_i` and registered state only; they have no dependency on `we_i`.

## Configuration
- Macro: `UART_TX_IRQ_EN`.
- Defined:
  - CTRL.irq_en is read/write.
  - `irq_o` is registered, computed as irq_en & empty & state==IDLE.
  - `irq_o` rises one cycle after the FSM enters IDLE with the FIFO empty. It falls one cycle after a push or after an irq_en clear.
- Undefined:
  - `irq_o` port and irq_en flop do not exist.
  - CTRL reads 0 and writes are ignored.

## Structure
- Add to `defines.v`:
  - `UART_TXDATA_OFF` (0), `UART_STATUS_OFF` (4), `UART_CTRL_OFF` (8).
  - Status bit indices `UART_ST_BUSY`, `UART_ST_FULL`, `UART_ST_EMPTY`, `UART_ST_OVF`.
  - FSM state encodings `UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP` (2-bit).
- Sub-module `uart_tx_fifo`:
  - Parameterised depth, 8-bit data.
  - Ports: push, pop, din, dout, full, empty.
  - Pointers one bit wider than the address for full/empty; wrap at FIFO_DEPTH.
- The top-level integration muxes `rdata_o` over `dpram` `data_o` when `sel_o` is high. It gates the `dpram` write with `~sel_o`.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Write 0x55 to +0:
  - `tx_o` carries 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles, starting one cycle after the write.
  - Line is high afterwards; STATUS=0x4.
- Write 0xA3 then 0x0F on consecutive cycles: two frames of 40 cycles each, with no idle cycle between them.
- Six writes in 6 cycles while idle:
  - The first pops immediately; the next four fill the FIFO; the sixth is dropped.
  - STATUS bits full=1, overflow=1. Only 5 frames are emitted.
  - Writing 0x8 to +4 clears overflow.
- Assert `rst_i` low during DATA bit 3 of 0xFF:
  - `tx_o`=1 immediately; STATUS=0x4 after release.
  - No further frame is emitted.
- Read +4, +8 and BASE_ADDR+16:
  - `sel_o`=1,1,0 respectively.
  - `rdata_o` correct for the first two and 0 for the third; a `dpram` write at +16 is not intercepted.
- With `UART_TX_IRQ_EN`:
  - Set irq_en, write 0x11.
  - `irq_o` is 0 during the frame and rises one cycle after the STOP bit ends.
  - Writing 0 to CTRL drops `irq_o` next cycle.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared widths, register map, status layout and FSM encoding for the MMIO UART transmitter.
package uart_tx_mmio_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned BIT_WIDTH  = 3;

  localparam int unsigned UART_TXDATA_OFF = 0;
  localparam int unsigned UART_STATUS_OFF = 4;
  localparam int unsigned UART_CTRL_OFF   = 8;
  localparam int unsigned UART_WIN_BYTES  = 12;

  localparam int unsigned UART_ST_BUSY  = 0;
  localparam int unsigned UART_ST_FULL  = 1;
  localparam int unsigned UART_ST_EMPTY = 2;
  localparam int unsigned UART_ST_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Field order matches the UART_ST_* bit indices (busy is bit 0).
  typedef struct packed {
    logic ovf;
    logic empty;
    logic full;
    logic busy;
  } uart_status_t;

  function automatic logic [1:0] reg_index(input int unsigned off);
    return 2'(off >> 2);
  endfunction

  localparam logic [1:0] REG_TXDATA = reg_index(UART_TXDATA_OFF);
  localparam logic [1:0] REG_STATUS = reg_index(UART_STATUS_OFF);
  localparam logic [1:0] REG_CTRL   = reg_index(UART_CTRL_OFF);

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus slice seen by the UART window: MEM-side write request plus combinational read-back.
interface uart_tx_mmio_if;
  import uart_tx_mmio_pkg::*;

  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  sel_o;
  logic [DATA_WIDTH-1:0] rdata_o;

  modport master (output we_i, addr_i, data_i, input  sel_o, rdata_o);
  modport slave  (input  we_i, addr_i, data_i, output sel_o, rdata_o);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the serialiser; pointers carry one extra wrap bit to tell full from empty.
module uart_tx_fifo
  import uart_tx_mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [BYTE_WIDTH-1:0] din,
  output logic [BYTE_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window, TX FIFO and bit serialiser.
// Optional interrupt output and CTRL.irq_en are built only when UART_TX_IRQ_EN is defined.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned           CLK_DIV    = 868,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_tx_mmio_if.slave  bus,
`ifdef UART_TX_IRQ_EN
  output logic           irq_o,
`endif
  output logic           tx_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(CLK_DIV - 1);

  logic [ADDR_WIDTH-1:0] offset;
  logic [1:0]            reg_idx;
  logic                  sel_c;
  logic                  wr_txdata;
  logic                  wr_status;
  logic                  wr_ctrl;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_data;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [BYTE_WIDTH-1:0] fifo_dout;

  uart_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]  bit_q, bit_d;
  logic [BYTE_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_d;
  logic                  ovf_q;
  uart_status_t          status;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
  assign offset      = bus.addr_i - BASE_ADDR;
  assign sel_c       = (offset < ADDR_WIDTH'(UART_WIN_BYTES));
  assign reg_idx     = offset[3:2];
  assign wr_txdata   = bus.we_i & sel_c & (reg_idx == REG_TXDATA);
  assign wr_status   = bus.we_i & sel_c & (reg_idx == REG_STATUS);
  assign wr_ctrl     = bus.we_i & sel_c & (reg_idx == REG_CTRL);
  assign unused_data = ^bus.data_i[DATA_WIDTH-1:BYTE_WIDTH];

  // A full FIFO still accepts the byte when the serialiser frees a slot on the same edge.
  assign fifo_push = wr_txdata & (~fifo_full | fifo_pop);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.data_i[BYTE_WIDTH-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow; a simultaneous drop beats a W1C clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else if (wr_txdata & fifo_full & ~fifo_pop) begin
      ovf_q <= 1'b1;
    end else if (wr_status & bus.data_i[UART_ST_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_o    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_o    <= tx_d;
    end
  end

  // Serialiser: every bit period ends when the baud counter reaches zero.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_o;
    fifo_pop = 1'b0;
    case (state_q)
      UART_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = CNT_RELOAD;
          tx_d     = 1'b0;
          state_d  = UART_START;
        end
      end
      UART_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = UART_DATA;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      UART_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == BIT_WIDTH'(BYTE_WIDTH - 1)) begin
            tx_d    = 1'b1;
            state_d = UART_STOP;
          end else begin
            bit_d   = bit_q + BIT_WIDTH'(1);
            shift_d = {1'b0, shift_q[BYTE_WIDTH-1:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      UART_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            cnt_d    = CNT_RELOAD;
            tx_d     = 1'b0;
            state_d  = UART_START;
          end else begin
            tx_d    = 1'b1;
            state_d = UART_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_en_q <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= bus.data_i[0];
      irq_o <= irq_en_q & fifo_empty & (state_q == UART_IDLE);
    end
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = wr_ctrl;
`endif

  assign status.busy  = (state_q != UART_IDLE);
  assign status.full  = fifo_full;
  assign status.empty = fifo_empty;
  assign status.ovf   = ovf_q;

  // Read port depends only on address and registered state.
  always_comb begin
    rdata_c = '0;
    if (sel_c) begin
      case (reg_idx)
        REG_STATUS: rdata_c = DATA_WIDTH'(status);
`ifdef UART_TX_IRQ_EN
        REG_CTRL:   rdata_c = DATA_WIDTH'(irq_en_q);
`endif
        default:    rdata_c = '0;
      endcase
    end
  end

  assign bus.sel_o   = sel_c;
  assign bus.rdata_o = rdata_c;

endmodule
